// File: rtl/gestor_interrupciones_pkg.sv
// rtl/gestor_interrupciones_pkg.sv - shared types, defaults and priority encoder
package gestor_interrupciones_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    SERV = 2'b10
  } estado_t;

  localparam int              N_IRQ_DEF      = 3;
  localparam int              VEC_W_DEF      = 10;
  localparam logic [9:0]      VEC_BASE_DEF   = 10'd1008;
  localparam int              VEC_STRIDE_DEF = 4;
  // id is 2 bits wide, so at most four lines can be encoded
  localparam int              MAX_IRQ        = 4;

  function automatic logic [1:0] prioridad(input logic [MAX_IRQ-1:0] req);
    logic [1:0] r;
    r = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gestor_interrupciones_sincronizador_flanco.sv
// rtl/gestor_interrupciones_sincronizador_flanco.sv - 2-flop synchroniser with rising-edge detector
module sincronizador_flanco
  import gestor_interrupciones_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic flanco
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign flanco = sync2_q & ~prev_q;

endmodule

// File: rtl/gestor_interrupciones.sv
// rtl/gestor_interrupciones.sv - interrupt controller: pending/mask registers and request FSM
module gestor_interrupciones
  import gestor_interrupciones_pkg::*;
#(
  parameter int               N_IRQ      = N_IRQ_DEF,
  parameter int               VEC_W      = VEC_W_DEF,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int               VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] interrupciones,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             ack,
  input  logic             fin,
  output logic             irq,
  output logic [VEC_W-1:0] vector,
  output logic [1:0]       id,
  output logic [N_IRQ-1:0] pendientes,
  output logic             ocupado
);

  estado_t          state_q, state_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [1:0]       id_q, id_d;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic             irq_q, irq_d;
  logic             ocupado_q, ocupado_d;

  logic [N_IRQ-1:0] flancos;
  logic [N_IRQ-1:0] cand_vec;
  logic [N_IRQ-1:0] clr;
  logic [1:0]       cand_id;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    sincronizador_flanco u_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (interrupciones[i]),
      .flanco (flancos[i])
    );
  end

  assign cand_vec = pend_q & ~mask_q;
  assign cand_id  = prioridad(MAX_IRQ'(cand_vec));

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    vector_d = vector_q;
    clr      = '0;
    mask_d   = mask_we ? mask_in : mask_q;
    case (state_q)
      IDLE: begin
        if (|cand_vec) begin
          id_d     = cand_id;
          vector_d = VEC_BASE + VEC_W'(cand_id) * VEC_W'(VEC_STRIDE);
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          clr     = N_IRQ'(1) << id_q;
          state_d = SERV;
        end
      end
      SERV: begin
        if (fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a fresh edge on the line being acknowledged keeps it pending
    pend_d    = (pend_q & ~clr) | flancos;
    irq_d     = (state_d == REQ);
    ocupado_d = (state_d == SERV);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      mask_q    <= '1;
      id_q      <= 2'd0;
      vector_q  <= VEC_BASE;
      irq_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      vector_q  <= vector_d;
      irq_q     <= irq_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign irq        = irq_q;
  assign vector     = vector_q;
  assign id         = id_q;
  assign pendientes = pend_q;
  assign ocupado    = ocupado_q;

endmodule
